instr_fetch_unit: RTL and testbench

- Upstream stage of the control unit: holds the PC, fetches instructions from a variable-latency instruction memory, and presents the instruction word (opcode/funct fields included) with a valid/ready handshake.
- Consumes pc_src and jump back from the control unit.
- Computes branch and jump targets from its own instruction register, then advances the PC.

---
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC holder and instruction fetcher with valid/ready handoff (optional FETCH_PERF_CNT_EN counters)
module instr_fetch_unit #(
   parameter int          ADDR_W   = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              pc_src,
   input  logic              jump,
   output logic [ADDR_W-1:0] pc,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]       fetch_count,
   output logic [31:0]       stall_count,
`endif
   output logic [ADDR_W-1:0] pc_plus4
);

   localparam logic [0:0] S_REQ   = 1'b0;
   localparam logic [0:0] S_VALID = 1'b1;

   logic [0:0]        state;
   logic [ADDR_W-1:0] next_pc;
   logic [31:0]       pc_plus4_ext;
   logic [31:0]       jump_target;
   logic [31:0]       branch_offset;
   logic              accept;

   assign imem_addr = pc;
   assign pc_plus4  = pc + ADDR_W'(4);
   assign accept    = (state == S_VALID) && instr_ready;

   // Target selection: jump beats branch beats sequential; all arithmetic wraps at ADDR_W.
   always_comb begin
      pc_plus4_ext  = 32'(pc_plus4);
      jump_target   = {pc_plus4_ext[31:28], instr[25:0], 2'b00};
      branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
      if (jump)
         next_pc = ADDR_W'(jump_target);
      else if (pc_src)
         next_pc = pc_plus4 + ADDR_W'(branch_offset);
      else
         next_pc = pc_plus4;
   end

   // REQ/VALID handshake FSM; the request is raised one edge after reset, so an ack on that edge is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_REQ;
         pc          <= ADDR_W'(RESET_PC);
         imem_req    <= 1'b0;
         instr       <= 32'h0;
         instr_valid <= 1'b0;
      end else if (state == S_REQ) begin
         if (!imem_req) begin
            imem_req <= 1'b1;
         end else if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= S_VALID;
         end
      end else begin
         if (instr_ready) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= S_REQ;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Saturating counters: accepts, and cycles spent waiting on an outstanding request.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count <= 32'h0;
         stall_count <= 32'h0;
      end else begin
         if (accept && fetch_count != 32'hFFFF_FFFF)
            fetch_count <= fetch_count + 32'h1;
         if (state == S_REQ && imem_req && !imem_ack && stall_count != 32'hFFFF_FFFF)
            stall_count <= stall_count + 32'h1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - table-driven bench for instr_fetch_unit
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        pc_src;
   logic        jump;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   int n_pass  = 0;
   int n_total = 0;

   instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .pc_src      (pc_src),
      .jump        (jump),
      .pc          (pc),
`ifdef FETCH_PERF_CNT_EN
      .fetch_count (fetch_count),
      .stall_count (stall_count),
`endif
      .pc_plus4    (pc_plus4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] rdata;
      int          mem_wait;
      int          ready_wait;
      logic        pc_src;
      logic        jump;
      logic [31:0] exp_next;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   task automatic run_fetch(input vec_t v);
      for (int i = 0; i < 20 && !imem_req; i++)
         tick();
      chk("req_seen", {31'b0, imem_req}, 32'h1);
      chk("req_addr", imem_addr, v.pc);
      chk("pc_plus4", pc_plus4, v.pc + 32'h4);
      for (int i = 0; i < v.mem_wait; i++) begin
         imem_ack   = 1'b0;
         imem_rdata = 32'hDEAD_BEEF;
         tick();
         chk("wait_state", {imem_req, instr_valid, imem_addr[29:0]}, {2'b10, v.pc[29:0]});
      end
      imem_ack   = 1'b1;
      imem_rdata = v.rdata;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      chk("valid_after_ack", {30'b0, instr_valid, imem_req}, 32'h2);
      chk("instr_captured", instr, v.rdata);
      for (int i = 0; i < v.ready_wait; i++) begin
         instr_ready = 1'b0;
         pc_src      = 1'b1;
         jump        = 1'b1;
         imem_ack    = 1'b1;
         imem_rdata  = 32'h5A5A_5A5A;
         tick();
         chk("hold_instr", instr, v.rdata);
         chk("hold_pc", pc, v.pc);
         chk("hold_flags", {30'b0, instr_valid, imem_req}, 32'h2);
      end
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      pc_src      = v.pc_src;
      jump        = v.jump;
      tick();
      instr_ready = 1'b0;
      pc_src      = 1'b0;
      jump        = 1'b0;
      chk("accept_flags", {30'b0, instr_valid, imem_req}, 32'h1);
      chk("next_addr", imem_addr, v.exp_next);
   endtask

   initial begin
      vec_t pv;
      //            pc            rdata         mw rw src jmp next
      vecs[0] = '{32'h0000_0000, 32'h1111_1111, 0, 0, 0, 0, 32'h0000_0004};
      vecs[1] = '{32'h0000_0004, 32'h2222_2222, 3, 4, 0, 0, 32'h0000_0008};
      vecs[2] = '{32'h0000_0008, 32'h3333_3333, 1, 0, 0, 0, 32'h0000_000C};
      vecs[3] = '{32'h0000_000C, 32'h0800_0040, 0, 1, 0, 1, 32'h0000_0100};
      vecs[4] = '{32'h0000_0100, 32'h1000_FFFE, 0, 0, 1, 0, 32'h0000_00FC};
      vecs[5] = '{32'h0000_00FC, 32'h0800_0010, 2, 0, 1, 1, 32'h0000_0040};
      vecs[6] = '{32'h0000_0040, 32'h1000_FFEE, 0, 0, 1, 0, 32'hFFFF_FFFC};
      vecs[7] = '{32'hFFFF_FFFC, 32'h0000_0020, 0, 2, 0, 0, 32'h0000_0000};
      vecs[8] = '{32'h0000_0000, 32'h1000_0003, 1, 0, 1, 0, 32'h0000_0010};
      vecs[9] = '{32'h0000_0010, 32'h1000_0003, 0, 0, 0, 0, 32'h0000_0014};

      rst         = 1'b1;
      imem_ack    = 1'b0;
      imem_rdata  = 32'h0;
      instr_ready = 1'b0;
      pc_src      = 1'b0;
      jump        = 1'b0;
      tick();
      tick();
      chk("rst_flags", {30'b0, imem_req, instr_valid}, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_fetch_count", fetch_count, 32'h0);
      chk("rst_stall_count", stall_count, 32'h0);
`endif

      rst        = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h0BAD_0BAD;
      tick();
      imem_ack   = 1'b0;
      chk("first_edge_req", {31'b0, imem_req}, 32'h1);
      chk("first_edge_ack_ignored", {31'b0, instr_valid}, 32'h0);

      for (int k = 0; k < 10; k++)
         run_fetch(vecs[k]);

      imem_ack   = 1'b1;
      imem_rdata = 32'h7777_7777;
      rst        = 1'b1;
      tick();
      chk("midreq_rst_flags", {30'b0, imem_req, instr_valid}, 32'h0);
      chk("midreq_rst_pc", pc, 32'h0);
      chk("midreq_rst_instr", instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("midreq_rst_fetch_count", fetch_count, 32'h0);
      chk("midreq_rst_stall_count", stall_count, 32'h0);
`endif
      rst      = 1'b0;
      imem_ack = 1'b0;
      tick();
      chk("post_rst_req", {31'b0, imem_req}, 32'h1);
      chk("post_rst_addr", imem_addr, 32'h0);

`ifdef FETCH_PERF_CNT_EN
      for (int k = 0; k < 3; k++) begin
         pv = '{32'(k * 4), 32'hC0DE_0000 + 32'(k), 2, 0, 0, 0, 32'((k + 1) * 4)};
         run_fetch(pv);
      end
      chk("fetch_count", fetch_count, 32'd3);
      chk("stall_count", stall_count, 32'd6);
`else
      pv = '{32'h0, 32'hC0DE_0000, 2, 0, 0, 0, 32'h4};
      run_fetch(pv);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
